match_count_display: RTL and testbench
======================================

// Module: match_count_display
// PURPOSE
// - Downstream stage of sequence_detector: consumes its match flag z, keeps a two-digit BCD count
//   of detected 01[0*]1 sequences and drives the two 7-segment digits (ones, tens).
// - Owns all counting and display encoding; the detector only produces the match flag.
// PARAMETERS
// SATURATE       0  1: count holds at 99 on overflow; 0: count wraps 99 -> 00
// BLANK_LEADING  0  1: tens digit blanked (all segments off) while tens == 0
// SEG_ACTIVE_LOW 0  1: segment outputs inverted (common-anode display)
// PORTS
// clk        in   1  system clock, rising edge
// rst        in   1  asynchronous, active-low reset
// ena        in   1  count enable; increments are discarded while low
// clr        in   1  synchronous clear of count and ovf
// match_in   in   1  match flag (z) from sequence_detector
// count_bcd  out  8  {tens,ones} BCD count, registered
// ovf        out  1  sticky overflow flag, registered
// disp0      out  7  ones digit segments {g,f,e,d,c,b,a}, registered
// disp1      out  7  tens digit segments {g,f,e,d,c,b,a}, registered
// BEHAVIOUR
// - One clock. Reset is asynchronous and active-low; all flops clear immediately on rst=0, independent of clk.
// - Reset values: match_q=0, match_qq=0, count_bcd=8'h00, ovf=0, disp0=seg(0), disp1=seg(0),
//   or SEG_BLANK if BLANK_LEADING=1. All values pass through SEG_ACTIVE_LOW inversion.
// - Input stage: match_q <= match_in; match_qq <= match_q (samples the combinational Mealy z).
// - inc = match_q & ~match_qq & ena. A rising edge counts once; a held-high match counts once.
// - ena=0 drops the edge; it is not deferred. Edge history still updates while ena=0.
// - Latency: match_in first sampled high at edge N; count_bcd updates at edge N+1;
//   disp0/disp1 update at edge N+2.
// - BCD increment: ones 9 -> 0 carries into tens; otherwise ones+1. Digits never leave 0..9.
// - Overflow (inc with count 8'h99):
//   - SATURATE=0: count -> 8'h00.
//   - SATURATE=1: count stays 8'h99.
//   - Both cases: ovf <= 1, sticky until clr or rst.
// - clr=1: count <= 8'h00 and ovf <= 0 at the next edge. clr wins over a simultaneous inc.
// - Edge history is not cleared by clr, so a match still high across clr is not recounted.
// - Display regs: disp0 <= seg(ones), disp1 <= (BLANK_LEADING && tens==0) ? SEG_BLANK : seg(tens).
// - Active-high encoding table: 0=3F 1=06 2=5B 3=4F 4=66 5=6D 6=7D 7=07 8=7F 9=6F, blank=00.
// - Outputs are ~code when SEG_ACTIVE_LOW=1.
// - No FSM beyond the two-flop edge detector; the count register is the only state of note.
// STRUCTURE
// - Shared package seq_det_pkg:
//   - typedef logic [3:0] bcd_t.
//   - typedef logic [6:0] seg_t.
//   - localparam seg_t SEG_DIGIT[10] (encoding table above).
//   - localparam seg_t SEG_BLANK.
// - The package is also imported by sequence_detector.
// - Sub-module bcd_to_7seg: combinational bcd_t -> seg_t with active-low inversion parameter.
//   - Instantiated twice (ones, tens).
//   - Codes 10..15 map to SEG_BLANK.
// - Edge detect, BCD counter, ovf and display registers live in match_count_display.
// TESTING
// 1. Reset with all parameters 0: rst=0 between edges -> count_bcd=8'h00, ovf=0, disp0=disp1=7'h3F
//    immediately.
// 2. Three 1-cycle match_in pulses, each followed by >=1 low cycle, ena=1 -> count_bcd=8'h03.
//    disp0=7'h4F and disp1=7'h3F, two edges after the last pulse is sampled.
// 3. match_in held high 5 cycles -> count_bcd +1 only.
//    Same pulse with ena=0 -> no change; re-enabling ena does not replay it.
// 4. 100 pulses:
//    - SATURATE=0 -> count_bcd=8'h00, ovf=1.
//    - SATURATE=1 -> count_bcd=8'h99, ovf=1, and a 101st pulse leaves 8'h99.
//    - Check 8'h09 -> 8'h10 carry on the way.
// 5. clr=1 in the same cycle inc fires, from count 8'h42, ovf=1 -> count_bcd=8'h00, ovf=0.
//    BLANK_LEADING=1 -> disp1=7'h00, disp0=7'h3F. SEG_ACTIVE_LOW=1 -> disp1=7'h7F, disp0=7'h40.
// 6. rst=0 mid-count (count_bcd=8'h42) asserted off-edge -> count_bcd=8'h00 and disp0=7'h3F immediately.
//    After release, the first pulse yields 8'h01.

Source files
------------

// File: rtl/seq_det_pkg.sv
// seq_det_pkg: shared types, 7-segment code table and BCD helper for the sequence detector path
package seq_det_pkg;

  typedef logic [3:0] bcd_t;
  typedef logic [6:0] seg_t;

  // Active-high segment codes {g,f,e,d,c,b,a} for digits 0..9
  localparam seg_t SEG_DIGIT [10] = '{
    7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66,
    7'h6D, 7'h7D, 7'h07, 7'h7F, 7'h6F
  };

  localparam seg_t SEG_BLANK = 7'h00;

  // Two-digit BCD +1; the caller handles 99 before calling, so tens never passes 9
  function automatic logic [7:0] bcd2_inc(input logic [7:0] v);
    return (v[3:0] == 4'd9) ? {v[7:4] + 4'd1, 4'd0} : {v[7:4], v[3:0] + 4'd1};
  endfunction

endpackage

// File: rtl/bcd_to_7seg.sv
// bcd_to_7seg: combinational BCD digit to 7-segment code, non-decimal codes shown blank
module bcd_to_7seg
  import seq_det_pkg::*;
#(
  parameter bit ACTIVE_LOW = 1'b0
) (
  input  bcd_t bcd_i,
  output seg_t seg_o
);

  seg_t code;

  assign code  = (bcd_i > 4'd9) ? SEG_BLANK : SEG_DIGIT[bcd_i];
  assign seg_o = ACTIVE_LOW ? ~code : code;

endmodule

// File: rtl/match_count_display.sv
// match_count_display: counts match-flag rising edges in two-digit BCD and drives two 7-segment digits
module match_count_display
  import seq_det_pkg::*;
#(
  parameter bit SATURATE       = 1'b0,
  parameter bit BLANK_LEADING  = 1'b0,
  parameter bit SEG_ACTIVE_LOW = 1'b0
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       ena,
  input  logic       clr,
  input  logic       match_in,
  output logic [7:0] count_bcd,
  output logic       ovf,
  output seg_t       disp0,
  output seg_t       disp1
);

  localparam seg_t SEG_OFF   = SEG_ACTIVE_LOW ? ~SEG_BLANK : SEG_BLANK;
  localparam seg_t SEG_ZERO  = SEG_ACTIVE_LOW ? ~SEG_DIGIT[0] : SEG_DIGIT[0];
  localparam seg_t DISP1_RST = BLANK_LEADING ? SEG_OFF : SEG_ZERO;

  logic       match_q, match_qq;
  logic       inc, at_max;
  logic [7:0] count_q, count_d;
  logic       ovf_q, ovf_d;
  seg_t       seg_ones, seg_tens;
  seg_t       disp0_q, disp1_q, disp1_d;

  // A held-high match counts once; ena gates the edge itself, so a masked edge is lost
  assign inc    = match_q & ~match_qq & ena;
  assign at_max = count_q == 8'h99;

  // Next count and sticky overflow; clr outranks a coinciding increment
  always_comb begin
    count_d = clr ? 8'h00 : !inc ? count_q : at_max ? (SATURATE ? 8'h99 : 8'h00) : bcd2_inc(count_q);
    ovf_d   = ~clr & (ovf_q | (inc & at_max));
    disp1_d = (BLANK_LEADING && count_q[7:4] == 4'd0) ? SEG_OFF : seg_tens;
  end

  bcd_to_7seg #(.ACTIVE_LOW(SEG_ACTIVE_LOW)) u_ones (
    .bcd_i (count_q[3:0]),
    .seg_o (seg_ones)
  );

  bcd_to_7seg #(.ACTIVE_LOW(SEG_ACTIVE_LOW)) u_tens (
    .bcd_i (count_q[7:4]),
    .seg_o (seg_tens)
  );

  // Two-flop edge history of the (possibly combinational) match flag; clr leaves it alone
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      match_q  <= 1'b0;
      match_qq <= 1'b0;
    end else begin
      match_q  <= match_in;
      match_qq <= match_q;
    end
  end

  // Count and overflow state
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      count_q <= 8'h00;
      ovf_q   <= 1'b0;
    end else begin
      count_q <= count_d;
      ovf_q   <= ovf_d;
    end
  end

  // Display registers follow the registered count one clock later
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      disp0_q <= SEG_ZERO;
      disp1_q <= DISP1_RST;
    end else begin
      disp0_q <= seg_ones;
      disp1_q <= disp1_d;
    end
  end

  assign count_bcd = count_q;
  assign ovf       = ovf_q;
  assign disp0     = disp0_q;
  assign disp1     = disp1_q;

endmodule

// File: tb/tb_match_count_display.sv
// tb_match_count_display: directed table, corner sequences and random run against a decimal reference model
module tb_match_count_display;

  localparam logic [6:0] SEG [10] = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07, 7'h7F, 7'h6F};

  logic clk = 1'b0;
  logic rst, ena, clr, match_in;
  logic [7:0] cnt_o [4];
  logic       ovf_o [4];
  logic [6:0] d0_o [4];
  logic [6:0] d1_o [4];

  int n_chk = 0;
  int n_pass = 0;

  // reference model: decimal count per configuration plus sampled match history
  int mcnt [4];
  int mshown [4];
  bit movf [4];
  bit samples [$];

  always #5 clk = ~clk;

  // 0: defaults, 1: saturate, 2: blank leading, 3: blank leading + active-low
  for (genvar g = 0; g < 4; g++) begin : g_dut
    match_count_display #(
      .SATURATE       (g == 1),
      .BLANK_LEADING  (g >= 2),
      .SEG_ACTIVE_LOW (g == 3)
    ) u_dut (
      .clk       (clk),
      .rst       (rst),
      .ena       (ena),
      .clr       (clr),
      .match_in  (match_in),
      .count_bcd (cnt_o[g]),
      .ovf       (ovf_o[g]),
      .disp0     (d0_o[g]),
      .disp1     (d1_o[g])
    );
  end

  function automatic bit cfg_sat(int s);  return s == 1; endfunction
  function automatic bit cfg_blk(int s);  return s >= 2; endfunction
  function automatic bit cfg_alow(int s); return s == 3; endfunction

  function automatic logic [6:0] exp_seg(int d, bit alow, bit blank_it);
    logic [6:0] v;
    v = blank_it ? 7'h00 : SEG[d];
    return alow ? ~v : v;
  endfunction

  task automatic chk(string name, logic [7:0] act, logic [7:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endtask

  task automatic model_reset();
    samples = {1'b0, 1'b0};
    for (int s = 0; s < 4; s++) begin
      mcnt[s] = 0;
      mshown[s] = 0;
      movf[s] = 1'b0;
    end
  endtask

  // advance the model by one clock edge using the inputs present at that edge
  task automatic model_edge(bit m, bit e, bit c);
    bit rise;
    rise = samples[$] && !samples[$-1] && e;
    samples.push_back(m);
    if (samples.size() > 3) void'(samples.pop_front());
    for (int s = 0; s < 4; s++) begin
      mshown[s] = mcnt[s];
      if (c) begin
        mcnt[s] = 0;
        movf[s] = 1'b0;
      end else if (rise) begin
        if (mcnt[s] == 99) begin
          movf[s] = 1'b1;
          mcnt[s] = cfg_sat(s) ? 99 : 0;
        end else mcnt[s]++;
      end
    end
  endtask

  task automatic check_all();
    for (int s = 0; s < 4; s++) begin
      chk($sformatf("cnt[%0d]", s), cnt_o[s], 8'((mcnt[s] / 10) * 16 + mcnt[s] % 10));
      chk($sformatf("ovf[%0d]", s), {7'd0, ovf_o[s]}, {7'd0, movf[s]});
      chk($sformatf("disp0[%0d]", s), {1'b0, d0_o[s]}, {1'b0, exp_seg(mshown[s] % 10, cfg_alow(s), 1'b0)});
      chk($sformatf("disp1[%0d]", s), {1'b0, d1_o[s]},
          {1'b0, exp_seg(mshown[s] / 10, cfg_alow(s), cfg_blk(s) && mshown[s] / 10 == 0)});
    end
  endtask

  // inputs change at the falling edge; outputs are checked at the next falling edge
  task automatic cycle(bit m, bit e, bit c);
    match_in = m;
    ena = e;
    clr = c;
    @(posedge clk);
    model_edge(m, e, c);
    @(negedge clk);
    check_all();
  endtask

  task automatic pulse();
    cycle(1'b1, 1'b1, 1'b0);
    cycle(1'b0, 1'b1, 1'b0);
  endtask

  // asynchronous reset asserted and released between clock edges
  task automatic do_reset();
    match_in = 1'b0;
    ena = 1'b1;
    clr = 1'b0;
    #2 rst = 1'b0;
    model_reset();
    #1;
    check_all();
    chk("rst_cnt", cnt_o[0], 8'h00);
    chk("rst_disp0", {1'b0, d0_o[0]}, 8'h3F);
    #1 rst = 1'b1;
  endtask

  typedef struct {
    bit m;
    bit e;
    bit c;
    logic [7:0] cnt;
    logic [6:0] d0;
  } vec_t;

  vec_t tbl [17];

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    // three pulses, then a 5-cycle hold, then a pulse while disabled
    tbl = '{
      '{1, 1, 0, 8'h00, 7'h3F}, '{0, 1, 0, 8'h01, 7'h3F}, '{1, 1, 0, 8'h01, 7'h06},
      '{0, 1, 0, 8'h02, 7'h06}, '{1, 1, 0, 8'h02, 7'h5B}, '{0, 1, 0, 8'h03, 7'h5B},
      '{0, 1, 0, 8'h03, 7'h4F}, '{1, 1, 0, 8'h03, 7'h4F}, '{1, 1, 0, 8'h04, 7'h4F},
      '{1, 1, 0, 8'h04, 7'h66}, '{1, 1, 0, 8'h04, 7'h66}, '{1, 1, 0, 8'h04, 7'h66},
      '{0, 1, 0, 8'h04, 7'h66}, '{0, 1, 0, 8'h04, 7'h66}, '{1, 0, 0, 8'h04, 7'h66},
      '{0, 0, 0, 8'h04, 7'h66}, '{0, 1, 0, 8'h04, 7'h66}
    };
    rst = 1'b1;
    match_in = 1'b0;
    ena = 1'b1;
    clr = 1'b0;
    #1 rst = 1'b0;
    model_reset();
    #1;
    chk("init_cnt", cnt_o[0], 8'h00);
    chk("init_ovf", {7'd0, ovf_o[0]}, 8'h00);
    chk("init_disp0", {1'b0, d0_o[0]}, 8'h3F);
    chk("init_disp1", {1'b0, d1_o[0]}, 8'h3F);
    chk("init_blank_disp1", {1'b0, d1_o[2]}, 8'h00);
    chk("init_alow_disp0", {1'b0, d0_o[3]}, 8'h40);
    chk("init_alow_disp1", {1'b0, d1_o[3]}, 8'h7F);
    check_all();
    @(negedge clk);
    rst = 1'b1;
    for (int i = 0; i < 17; i++) begin
      cycle(tbl[i].m, tbl[i].e, tbl[i].c);
      chk($sformatf("tbl%0d_cnt", i), cnt_o[0], tbl[i].cnt);
      chk($sformatf("tbl%0d_disp0", i), {1'b0, d0_o[0]}, {1'b0, tbl[i].d0});
    end
    // 101 pulses: carry, wrap vs saturate, sticky ovf
    do_reset();
    for (int i = 1; i <= 101; i++) begin
      pulse();
      if (i == 9) chk("carry_09", cnt_o[0], 8'h09);
      if (i == 10) chk("carry_10", cnt_o[0], 8'h10);
      if (i == 100) begin
        chk("wrap_cnt", cnt_o[0], 8'h00);
        chk("wrap_ovf", {7'd0, ovf_o[0]}, 8'h01);
        chk("sat_cnt", cnt_o[1], 8'h99);
        chk("sat_ovf", {7'd0, ovf_o[1]}, 8'h01);
      end
    end
    chk("sat_101", cnt_o[1], 8'h99);
    chk("wrap_101", cnt_o[0], 8'h01);
    // clr coinciding with an increment from 42 with ovf set
    for (int i = 0; i < 41; i++) pulse();
    chk("pre_clr_cnt", cnt_o[0], 8'h42);
    chk("pre_clr_ovf", {7'd0, ovf_o[0]}, 8'h01);
    cycle(1'b1, 1'b1, 1'b0);
    cycle(1'b0, 1'b1, 1'b1);
    chk("clr_cnt", cnt_o[0], 8'h00);
    chk("clr_ovf", {7'd0, ovf_o[0]}, 8'h00);
    cycle(1'b0, 1'b1, 1'b0);
    chk("clr_blank_disp1", {1'b0, d1_o[2]}, 8'h00);
    chk("clr_blank_disp0", {1'b0, d0_o[2]}, 8'h3F);
    chk("clr_alow_disp1", {1'b0, d1_o[3]}, 8'h7F);
    chk("clr_alow_disp0", {1'b0, d0_o[3]}, 8'h40);
    // match held high across clr is not counted again
    cycle(1'b1, 1'b1, 1'b0);
    cycle(1'b1, 1'b1, 1'b1);
    cycle(1'b1, 1'b1, 1'b0);
    cycle(1'b0, 1'b1, 1'b0);
    chk("held_across_clr", cnt_o[0], 8'h00);
    // asynchronous reset mid-count
    for (int i = 0; i < 42; i++) pulse();
    chk("pre_rst_cnt", cnt_o[0], 8'h42);
    do_reset();
    pulse();
    chk("post_rst_cnt", cnt_o[0], 8'h01);
    // random traffic against the model
    for (int i = 0; i < 400; i++)
      cycle(($urandom % 3) != 0, ($urandom % 8) != 0, ($urandom % 50) == 0);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
